// File: rtl/row_group_pkg.sv
// row_group_pkg: shared state encoding and sizing helpers for the row group scheduler
package row_group_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_STREAM, ST_DONE} state_t;
    localparam int DEF_NUM_ROWS   = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_SKEW_WIDTH = 2;
    function automatic int cnt_bits(input int rows, input int skew_w);
        return $clog2((rows - 1) * (2 ** skew_w - 1) + 2);
    endfunction
endpackage

// File: rtl/rg_row_fifo.sv
// rg_row_fifo: per-row synchronous FIFO with a registered read word
module rg_row_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wptr, r_rptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_push, w_pop;
    assign o_empty = r_wptr == r_rptr;
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_data;
    // storage array; the pointers alone decide which entries are live
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
    // pointer update and read-word register, which holds its value between pops
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_data <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
                r_data <= r_mem[r_rptr[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/row_group_scheduler.sv
// row_group_scheduler: buffers per-row words and drains them with a programmable systolic skew
module row_group_scheduler import row_group_pkg::*; #(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SKEW_WIDTH = DEF_SKEW_WIDTH,
    parameter int CNT_WIDTH  = cnt_bits(NUM_ROWS, SKEW_WIDTH)
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_reg_clear,
    input  logic [NUM_ROWS-1:0]            i_row_mask,
    input  logic [SKEW_WIDTH-1:0]          i_skew,
    input  logic                           i_start,
    input  logic                           i_stall,
    input  logic                           i_wr_valid,
    input  logic [$clog2(NUM_ROWS)-1:0]    i_wr_row,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    output logic                           o_wr_ready,
    input  logic                           i_wr_last,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] o_data,
    output logic [NUM_ROWS-1:0]            o_data_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_underflow
);
    localparam int RW = $clog2(NUM_ROWS);
    state_t                r_state, w_next;
    logic [CNT_WIDTH-1:0]  r_cnt, w_ramp_end;
    logic [CNT_WIDTH-1:0]  w_thresh [NUM_ROWS];
    logic [NUM_ROWS-1:0]   r_mask, r_valid, w_active, w_pop, w_push, w_empty, w_full;
    logic [SKEW_WIDTH-1:0] r_skew;
    logic                  r_last, r_underflow, w_nrst, w_busy, w_run, w_underrun;
    assign w_nrst       = i_nrst & ~i_reg_clear;
    assign w_busy       = (r_state == ST_RAMP) || (r_state == ST_STREAM);
    assign w_run        = w_busy & ~i_stall;
    assign w_underrun   = |(w_active & w_empty) & ~i_stall & ~r_last;
    assign o_wr_ready   = ~w_full[i_wr_row] & (r_state != ST_DONE);
    assign o_data_valid = r_valid;
    assign o_busy       = w_busy;
    assign o_done       = r_state == ST_DONE;
    assign o_underflow  = r_underflow;
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        assign w_thresh[r] = CNT_WIDTH'(r_skew) * CNT_WIDTH'(r);
        assign w_active[r] = w_busy & r_mask[r] & (r_cnt >= w_thresh[r]);
        assign w_pop[r]    = w_active[r] & ~i_stall & ~w_empty[r];
        assign w_push[r]   = i_wr_valid & o_wr_ready & (i_wr_row == RW'(r));
        rg_row_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk     (i_clk),
            .i_nrst    (w_nrst),
            .i_push    (w_push[r]),
            .i_wr_data (i_wr_data),
            .i_pop     (w_pop[r]),
            .o_full    (w_full[r]),
            .o_empty   (w_empty[r]),
            .o_data    (o_data[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end
    // the ramp ends once the highest enabled row has reached its launch point
    always_comb begin
        w_ramp_end = '0;
        for (int k = 0; k < NUM_ROWS; k++) w_ramp_end = r_mask[k] ? w_thresh[k] : w_ramp_end;
    end
    // launch/drain sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = (|i_row_mask) ? ST_RAMP : ST_DONE;
            ST_RAMP:   if (r_cnt >= w_ramp_end) w_next = ST_STREAM;
            ST_STREAM: if (r_last && !(|(r_mask & ~w_empty)) && !(|w_pop)) w_next = ST_DONE;
            default:   w_next = ST_IDLE;
        endcase
    end
    // state register
    always_ff @(posedge i_clk) begin
        r_state <= !w_nrst ? ST_IDLE : w_next;
    end
    // launch configuration, skew counter, last-write latch, sticky underflow and row valids
    always_ff @(posedge i_clk) begin
        if (!w_nrst) begin
            r_cnt       <= '0;
            r_mask      <= '0;
            r_skew      <= '0;
            r_last      <= 1'b0;
            r_underflow <= 1'b0;
            r_valid     <= '0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_mask <= i_row_mask;
                r_skew <= i_skew;
                r_cnt  <= '0;
            end else if (w_run && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            r_last      <= (r_state == ST_DONE) ? 1'b0 : (r_last | i_wr_last);
            r_underflow <= r_underflow | w_underrun;
            r_valid     <= w_pop;
        end
    end
endmodule

// File: doc/row_group_scheduler.md
Name: row_group_scheduler

Overview:
Parametrised successor to the input-router row group. Buffers per-row activation words in NUM_ROWS small FIFOs, written through a row-addressed write port. Drains them into the PE array with a runtime-programmable systolic skew: row r starts popping skew*r enabled cycles after launch. Adds a row-enable mask, array backpressure, a launch/drain state machine, and a sticky underflow flag.

Parameters:
NUM_ROWS, 4, number of rows/FIFOs (≥2)
DATA_WIDTH, 8, bits per data word
FIFO_DEPTH, 8, entries per row FIFO (power of 2, ≥2)
SKEW_WIDTH, 2, width of runtime skew value
CNT_WIDTH, $clog2((NUM_ROWS-1)*(2**SKEW_WIDTH-1)+2), launch counter width (derived)

Ports:
i_clk  in  1  clock
i_nrst  in  1  synchronous active-low reset, sampled on rising edge of i_clk
i_reg_clear  in  1  synchronous clear; same effect as reset
i_row_mask  in  NUM_ROWS  1 = row enabled; sampled at launch
i_skew  in  SKEW_WIDTH  launch stagger in cycles per row; sampled at launch
i_start  in  1  launch request, honoured only in IDLE
i_stall  in  1  array backpressure; freezes the launch counter and all pops
i_wr_valid  in  1  write strobe
i_wr_row  in  $clog2(NUM_ROWS)  target row of write
i_wr_data  in  DATA_WIDTH  write data
o_wr_ready  out  1  target FIFO not full (combinational on i_wr_row)
i_wr_last  in  1  no more writes this tile; pulse, latched internally
o_data  out  NUM_ROWS*DATA_WIDTH  per-row output word, registered
o_data_valid  out  NUM_ROWS  per-row valid, registered
o_busy  out  1  state is RAMP or STREAM
o_done  out  1  one-cycle pulse on entering DONE
o_underflow  out  1  sticky: an active enabled row found its FIFO empty before last

Behaviour:
- Reset or i_reg_clear: FIFOs emptied, state IDLE, counter 0, wr_last latch 0, all outputs 0.
- Write: accepted when i_wr_valid & o_wr_ready. A write to a full FIFO is dropped with no state change. Writes are legal in every state except DONE.
- States: IDLE -> RAMP on i_start (mask and skew latched). RAMP -> STREAM when counter ≥ skew*(highest enabled row). STREAM -> DONE when wr_last is latched and every enabled FIFO is empty and no pop is in flight. DONE -> IDLE next cycle. If the mask is all-zero at start: IDLE -> DONE directly.
- Counter: increments each cycle in RAMP and STREAM when i_stall=0. Saturates at its maximum.
- Row r is active when enabled and counter ≥ skew*r. skew=0 means all rows launch together.
- Pop: an active row with i_stall=0 and a non-empty FIFO pops. o_data[r] and o_data_valid[r] are updated on the next edge (1-cycle latency).
- Row valid low: when not popping, o_data_valid[r] is driven 0 and o_data[r] holds its last value.
- Disabled rows: never pop, valid always 0, treated as empty for DONE.
- Stall: i_stall=1 forces all o_data_valid to 0 on the next edge. The counter and FIFO contents are frozen.
- Underflow: an active enabled row, not stalled, empty FIFO, wr_last not latched -> o_underflow set. It stays set until reset or clear. That row emits a bubble (valid 0).
- Simultaneous write and pop on the same FIFO: both occur; occupancy is unchanged. A write into an empty FIFO is not poppable the same cycle (no bypass).
- i_start outside IDLE is ignored. Reset mid-operation aborts the tile immediately.

Decomposition:
- row_group_pkg: state enum (ST_IDLE, ST_RAMP, ST_STREAM, ST_DONE), clog2 helper constants.
- One sub-module, rg_row_fifo: synchronous FIFO with push/pop/full/empty and registered output. The top instantiates it NUM_ROWS times via generate.

Test Plan:
- Basic launch: mask=4'b1111, skew=1, 3 words per row preloaded, start. First valid appears 1/2/3/4 cycles after start for rows 0/1/2/3. Each row emits 3 words in order. o_done pulses once after wr_last.
- skew=0 vs skew=3: all rows start in the same cycle; with skew=3, row 3 first valid is 10 cycles after start.
- Mask: mask=4'b0101, 2 words in rows 0/2, words also written to rows 1/3. Rows 1/3 never assert valid. DONE is reached with rows 1/3 non-empty.
- Stall: assert i_stall for 3 cycles mid-stream. Valid is 0 for those 3 cycles, no words are lost, and the total valid count per row equals the write count.
- Boundaries: FIFO_DEPTH=8, write 9 words to row 0; the 9th is refused (o_wr_ready=0). Starve row 1 before wr_last -> o_underflow=1, and it stays 1 until i_reg_clear.
- Reset: i_nrst low mid-RAMP. Next cycle state is IDLE, all valid 0, o_busy 0, and the FIFOs are empty.
